seq_mult4: RTL and testbench
============================

SEQ_MULT4 -- requirements
Module: seq_mult4

Interface
REQ-001 Parameter W, default 10, operand width in bits (W >= 2).
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 RST  input  1  reset, asynchronous, active-high.
REQ-004 START  input  1  request pulse; sampled only in IDLE or DONE state.
REQ-005 A  input  W  multiplicand, unsigned; sampled on accepted START edge only.
REQ-006 B  input  W  multiplier, unsigned; sampled on accepted START edge only.
REQ-007 P  output  2W  product A*B, registered; held stable until next accepted START.
REQ-008 BUSY  output  1  high while an operation is in progress (RUN state).
REQ-009 DONE  output  1  one-cycle pulse marking P valid.
REQ-010 IO  output  W  remaining-iteration count, mirrors the divider step's iteration port.

Function
REQ-011 The block SHALL compute P = A*B with a radix-4 shift-add algorithm, retiring 2 multiplier bits per RUN cycle.
REQ-012 K SHALL equal ceil(W/2); for odd W, B SHALL be zero-extended by one bit.
REQ-013 Partial product per step SHALL be selected from {0, A, 2A, 3A} by the 2 low multiplier bits; 3A SHALL be precomputed once at START acceptance into a W+2-bit register.
REQ-014 Accumulator width SHALL be W+2 bits high part plus the multiplier shift register; no intermediate overflow SHALL occur for any unsigned operands.
REQ-015 States: IDLE, RUN, DONE (3 states, binary encoded).
REQ-016 IDLE: START=1 at edge t -> load operands, clear accumulator, IO=K, go RUN; BUSY=1 from t.
REQ-017 RUN: each edge performs one step and decrements IO; the step with IO=1 writes P and moves to DONE, i.e. DONE high in the cycle following edge t+K.
REQ-018 DONE: DONE=1, BUSY=0 for exactly one cycle; START=1 in this cycle SHALL be accepted as in IDLE (back-to-back), else go IDLE.
REQ-019 START during RUN SHALL be ignored; A/B changes during RUN SHALL not affect the result.
REQ-020 A=0 or B=0 SHALL still take the full K cycles (fixed latency) and yield P=0.
REQ-021 IO SHALL read 0 in IDLE and DONE.

Reset
REQ-022 RST=1 SHALL immediately force state IDLE, P=0, BUSY=0, DONE=0, IO=0, all internal registers 0, regardless of CLK.
REQ-023 Reset asserted mid-RUN SHALL abort the operation with no DONE pulse; first START after RST deassertion starts a clean operation.

Structure
REQ-024 State encodings (IDLE=0, RUN=1, DONE=2) SHALL live in the shared FPU constants package/include, alongside the divider's constants.
REQ-025 One combinational sub-module mult4_step SHALL implement a single radix-4 step (inputs: accumulator, multiplier bits, A, 3A; outputs: next accumulator and shifted multiplier), parameterised by W.
REQ-026 seq_mult4 SHALL contain only the FSM, counter, operand/3A registers and one mult4_step instance.

Verification (W=10, K=5)
REQ-027 A=10, B=5, START 1 cycle -> BUSY 5 cycles, DONE pulse in 6th cycle after START edge, P=50, IO sequence 5,4,3,2,1,0.
REQ-028 A=86, B=14 -> P=1204; A=1023, B=1023 -> P=1046529 (max, checks 3A and width).
REQ-029 A=0, B=1023 -> P=0 after full 5-cycle latency.
REQ-030 START held high with A=3,B=7 then A=9,B=9 presented during RUN -> only P=21 produced; the START present during DONE cycle launches second op with A=9,B=9 -> P=81 exactly 6 cycles later.
REQ-031 RST pulsed during 3rd RUN cycle of A=100,B=100 -> outputs 0 asynchronously, no DONE; subsequent A=12,B=12 -> P=144.

Source files
------------

// File: rtl/seq_mult4_pkg.sv
// -----------------------------------------------------------------------------
// seq_mult4_pkg -- shared FPU sequencing constants.
//
// Holds the state encodings of the multi-cycle FPU helpers (the radix-4
// multiplier and the restoring divider) so both blocks, and anything that
// decodes their state, agree on one set of values.
// -----------------------------------------------------------------------------
package seq_mult4_pkg;

  // Radix-4 multiplier control states.
  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_RUN  = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_e;

  // Divider control states, same numbering as the multiplier.
  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  // Default operand width shared by the multiplier and divider.
  localparam int FPU_DEFAULT_W = 10;

  // Radix-4 retires two multiplier bits per step; odd widths need one
  // extra step with the multiplier zero-extended by one bit.
  function automatic int radix4_steps(input int w);
    return (w + 1) / 2;
  endfunction

endpackage

// File: rtl/seq_mult4_step.sv
// -----------------------------------------------------------------------------
// mult4_step -- one combinational radix-4 shift-add step.
//
// Ports:
//   acc        [W+1:0]   high accumulator part
//   mplr       [2K-1:0]  multiplier shift register (low product bits fill in
//                        from the top as multiplier bits retire at the bottom)
//   a          [W-1:0]   multiplicand
//   a3         [W+1:0]   precomputed 3*a
//   acc_next   [W+1:0]   accumulator after this step
//   mplr_next  [2K-1:0]  shift register after this step
//
// The accumulator never exceeds a (acc' = (acc + pp) / 4 <= (a + 3a) / 4),
// so a W+3-bit sum cannot overflow.
// -----------------------------------------------------------------------------
module mult4_step
  import seq_mult4_pkg::*;
#(
  parameter int W = FPU_DEFAULT_W
) (
  input  logic [W+1:0]                   acc,
  input  logic [2*radix4_steps(W)-1:0]   mplr,
  input  logic [W-1:0]                   a,
  input  logic [W+1:0]                   a3,
  output logic [W+1:0]                   acc_next,
  output logic [2*radix4_steps(W)-1:0]   mplr_next
);

  localparam int MW = 2 * radix4_steps(W);

  logic [W+1:0] pp;
  logic [W+2:0] sum;

  // NOTE: every signal written in an always_comb gets a value on every path
  // (here via the full case plus a leading default) so no latch is inferred.
  always_comb begin
    pp = '0;
    unique case (mplr[1:0])
      2'd0: pp = '0;
      2'd1: pp = {2'b00, a};
      2'd2: pp = {1'b0, a, 1'b0};
      2'd3: pp = a3;
    endcase
  end

  assign sum       = {1'b0, acc} + {1'b0, pp};
  // The two low sum bits are final product bits; they enter the shift
  // register from the top as the two consumed multiplier bits leave.
  assign acc_next  = {1'b0, sum[W+2:2]};
  assign mplr_next = {sum[1:0], mplr[MW-1:2]};

endmodule

// File: rtl/seq_mult4.sv
// -----------------------------------------------------------------------------
// seq_mult4 -- sequential unsigned multiplier, radix-4 shift-add.
//
// Ports:
//   clk    sole clock, rising edge
//   rst    asynchronous, active-high reset
//   start  request; accepted in IDLE or DONE only
//   a, b   [W-1:0] unsigned operands, captured on the accepting edge
//   p      [2W-1:0] registered product, held until the next result is written
//   busy   high in RUN
//   done   one-cycle pulse, p valid
//   io     [W-1:0] remaining-iteration count (K after accept, 0 when idle)
//
// Latency is fixed at K = ceil(W/2) RUN cycles regardless of operand values.
// -----------------------------------------------------------------------------
module seq_mult4
  import seq_mult4_pkg::*;
#(
  parameter int W = FPU_DEFAULT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  output logic [2*W-1:0]   p,
  output logic             busy,
  output logic             done,
  output logic [W-1:0]     io
);

  localparam int K  = radix4_steps(W);
  localparam int MW = 2 * K;

  mul_state_e    state_q, state_d;
  logic          load;

  logic [W-1:0]  a_q;
  logic [W+1:0]  a3_q;
  logic [W+1:0]  acc_q, acc_next;
  logic [MW-1:0] mplr_q, mplr_next;

  mult4_step #(.W(W)) u_step (
    .acc       (acc_q),
    .mplr      (mplr_q),
    .a         (a_q),
    .a3        (a3_q),
    .acc_next  (acc_next),
    .mplr_next (mplr_next)
  );

  // Next-state logic; start is only honoured in IDLE and DONE.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    unique case (state_q)
      MUL_IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = MUL_RUN;
        end
      end
      MUL_RUN: begin
        if (io == W'(1)) state_d = MUL_DONE;
      end
      MUL_DONE: begin
        if (start) begin
          load    = 1'b1;
          state_d = MUL_RUN;
        end else begin
          state_d = MUL_IDLE;
        end
      end
      default: state_d = MUL_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= MUL_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      a3_q   <= '0;
      acc_q  <= '0;
      mplr_q <= '0;
      io     <= '0;
      p      <= '0;
    end else if (load) begin
      a_q    <= a;
      a3_q   <= {2'b00, a} + {1'b0, a, 1'b0};
      acc_q  <= '0;
      mplr_q <= MW'(b);
      io     <= W'(K);
    end else if (state_q == MUL_RUN) begin
      acc_q  <= acc_next;
      mplr_q <= mplr_next;
      io     <= io - W'(1);
      // Final step: {acc, mplr} now holds the full product.
      if (io == W'(1)) p <= (2*W)'({acc_next, mplr_next});
    end
  end

  assign busy = (state_q == MUL_RUN);
  assign done = (state_q == MUL_DONE);

endmodule

// File: tb/tb_seq_mult4.sv
// -----------------------------------------------------------------------------
// tb_seq_mult4 -- self-checking bench for seq_mult4 at W=10 (K=5).
// -----------------------------------------------------------------------------
module tb_seq_mult4;

  localparam int W = 10;
  localparam int K = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [W-1:0]    a, b;
  logic [2*W-1:0]  p;
  logic            busy, done;
  logic [W-1:0]    io;

  int errors = 0;
  int checks = 0;

  logic [2*W-1:0] exp_q[$];

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] p;
  } vec_t;

  vec_t vecs[$];

  seq_mult4 #(.W(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .p     (p),
    .busy  (busy),
    .done  (done),
    .io    (io)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Compare p against the oldest scoreboard entry.
  task automatic pop_check(input string name);
    logic [2*W-1:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: result with empty scoreboard, got %0d expected none", name, p);
    end else begin
      e = exp_q.pop_front();
      check(name, 32'(p), 32'(e));
    end
  endtask

  // Samples after edge t+k for k=0..K: io counts K..0, busy for k<K,
  // done exactly at k=K, then result compared.
  task automatic watch_run(input string name);
    for (int k = 0; k <= K; k++) begin
      check({name, " io"},   32'(io),   32'(K - k));
      check({name, " busy"}, 32'(busy), 32'(k < K));
      check({name, " done"}, 32'(done), 32'(k == K));
      if (k == K) pop_check({name, " p"});
      if (k < K) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic do_op(input string name, input logic [W-1:0] av,
                       input logic [W-1:0] bv, input logic [2*W-1:0] pv);
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    exp_q.push_back(pv);
    @(posedge clk); #1;
    start = 1'b0;
    a = ~av; b = ~bv;  // operand changes during RUN must not matter
    watch_run(name);
    @(posedge clk); #1;
    check({name, " done drop"}, 32'(done), 32'd0);
    check({name, " p hold"},    32'(p),    32'(pv));
  endtask

  initial begin
    vecs.push_back('{10'd10,   10'd5,    20'd50});
    vecs.push_back('{10'd86,   10'd14,   20'd1204});
    vecs.push_back('{10'd1023, 10'd1023, 20'd1046529});
    vecs.push_back('{10'd0,    10'd1023, 20'd0});
    vecs.push_back('{10'd1023, 10'd0,    20'd0});
    vecs.push_back('{10'd1,    10'd1,    20'd1});
    vecs.push_back('{10'd512,  10'd3,    20'd1536});
    vecs.push_back('{10'd3,    10'd1023, 20'd3069});
    vecs.push_back('{10'd682,  10'd341,  20'd232562});

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    #1;
    check("reset p",    32'(p),    32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset io",   32'(io),   32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("idle io",   32'(io),   32'd0);
    check("idle busy", 32'(busy), 32'd0);

    foreach (vecs[i])
      do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].p);

    // Start held high: second request presented during RUN is ignored until
    // the DONE cycle, which then launches it back-to-back.
    @(negedge clk);
    a = 10'd3; b = 10'd7; start = 1'b1;
    exp_q.push_back(20'd21);
    @(posedge clk); #1;
    a = 10'd9; b = 10'd9;
    watch_run("b2b first");
    exp_q.push_back(20'd81);
    @(posedge clk); #1;
    start = 1'b0;
    watch_run("b2b second");
    @(posedge clk); #1;
    check("b2b idle", 32'(done), 32'd0);

    // Reset during the 3rd RUN cycle aborts without a done pulse.
    @(negedge clk);
    a = 10'd100; b = 10'd100; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("abort pre io",   32'(io),   32'd3);
    check("abort pre busy", 32'(busy), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort p",    32'(p),    32'd0);
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort io",   32'(io),   32'd0);
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    for (int c = 0; c < 2 * K; c++) begin
      @(posedge clk); #1;
      check("abort no done", 32'(done), 32'd0);
      check("abort no busy", 32'(busy), 32'd0);
    end
    do_op("after rst", 10'd12, 10'd12, 20'd144);

    check("scoreboard empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety bound so a stuck run still ends with a summary.
  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: simulation exceeded time budget, got running expected finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
